// File: rtl/rr_arbiter_dataless.sv
// Round-robin arbiter merging NUM_INPUTS dataless handshake requesters onto one registered output.
// Define RR_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module rr_arbiter_dataless #(
  parameter int NUM_INPUTS  = 4,
  parameter int INDEX_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_INPUTS-1:0]  ins_valid,
  output logic [NUM_INPUTS-1:0]  ins_ready,
  output logic                   outs_valid,
  input  logic                   outs_ready,
  output logic [INDEX_WIDTH-1:0] index
);

  localparam int SEL_W = $clog2(NUM_INPUTS);

  logic                   out_valid_q;
  logic [INDEX_WIDTH-1:0] index_q;
  logic                   can_accept;
  logic                   found;
  logic                   xfer;
  logic [SEL_W-1:0]       sel;
  logic [NUM_INPUTS-1:0]  grant;

`ifdef RR_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = '0;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (ins_valid[i] && !found) begin
        grant[i] = 1'b1;
        sel      = SEL_W'(i);
        found    = 1'b1;
      end
    end
  end
`else
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W:0]   pos;

  // Scan ptr, ptr+1, ... with wrap at NUM_INPUTS; first valid requester wins.
  always_comb begin
    grant = '0;
    sel   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      pos = {1'b0, ptr_q} + (SEL_W+1)'(k);
      if (pos >= (SEL_W+1)'(NUM_INPUTS)) begin
        pos = pos - (SEL_W+1)'(NUM_INPUTS);
      end
      if (ins_valid[pos[SEL_W-1:0]] && !found) begin
        grant[pos[SEL_W-1:0]] = 1'b1;
        sel                   = pos[SEL_W-1:0];
        found                 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (xfer) begin
      ptr_q <= (sel == SEL_W'(NUM_INPUTS-1)) ? '0 : sel + SEL_W'(1);
    end
  end
`endif

  assign can_accept = ~out_valid_q | outs_ready;
  assign ins_ready  = grant & {NUM_INPUTS{can_accept}};
  assign xfer       = found & can_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      index_q     <= '0;
    end else begin
      out_valid_q <= xfer | (out_valid_q & ~outs_ready);
      if (xfer) begin
        index_q <= INDEX_WIDTH'(sel);
      end
    end
  end

  assign outs_valid = out_valid_q;
  assign index      = index_q;

endmodule

// File: tb/tb_rr_arbiter_dataless.sv
// Self-checking bench for rr_arbiter_dataless: scoreboard of accepted indices plus a 3-input instance.
module tb_rr_arbiter_dataless;

  localparam int N = 4;
`ifdef RR_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ins_valid = '0;
  logic [3:0] ins_ready;
  logic       outs_valid;
  logic       outs_ready = 1'b0;
  logic [1:0] index;

  logic [2:0] ins_valid3 = '0;
  logic [2:0] ins_ready3;
  logic       outs_valid3;
  logic       outs_ready3 = 1'b0;
  logic [1:0] index3;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int m_ptr = 0;
  bit m_valid = 1'b0;
  int held;

  rr_arbiter_dataless #(.NUM_INPUTS(4), .INDEX_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .outs_valid(outs_valid), .outs_ready(outs_ready), .index(index)
  );

  rr_arbiter_dataless #(.NUM_INPUTS(3), .INDEX_WIDTH(2)) dut3 (
    .clk(clk), .rst(rst), .ins_valid(ins_valid3), .ins_ready(ins_ready3),
    .outs_valid(outs_valid3), .outs_ready(outs_ready3), .index(index3)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // One cycle: drive at negedge, check ready before the edge, check registered outputs after it.
  task automatic applyStimulus(input logic [3:0] v, input logic r);
    int         g;
    bit         can;
    logic [3:0] exp_ready;
    @(negedge clk);
    ins_valid  = v;
    outs_ready = r;
    #2;
    can = !m_valid || r;
    g   = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (g < 0 && v[j]) g = j;
    end
    exp_ready = (g >= 0 && can) ? 4'(1 << g) : 4'b0000;
    checkOutput("ins_ready", ins_ready, exp_ready);
    if (m_valid && r && exp_q.size() > 0) begin
      checkOutput("index_consumed", index, exp_q.pop_front());
    end
    if (exp_ready != 4'b0000) begin
      exp_q.push_back(g);
      if (!FIXED) m_ptr = (g + 1) % N;
    end
    m_valid = (exp_ready != 4'b0000) || (m_valid && !r);
    @(posedge clk);
    #1;
    checkOutput("outs_valid", outs_valid, m_valid);
    if (m_valid && exp_q.size() > 0) begin
      checkOutput("index_held", index, exp_q[0]);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outs_valid", outs_valid, 0);
    checkOutput("reset_index", index, 0);
    checkOutput("reset_outs_valid3", outs_valid3, 0);
    @(negedge clk);
    rst = 1'b0;

    repeat (8) applyStimulus(4'b1111, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    repeat (4) applyStimulus(4'b1010, 1'b1);

    // Hold the last token while input 2 waits behind a stalled consumer.
    held = exp_q[0];
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0100, 1'b0);
      checkOutput("stall_index", index, held);
    end
    applyStimulus(4'b0100, 1'b1);
    checkOutput("resume_index", index, 2);
    applyStimulus(4'b0000, 1'b1);

    // Leave the pointer at 2 with a stalled token, then reset asynchronously mid-cycle.
    applyStimulus(4'b0010, 1'b1);
    applyStimulus(4'b0000, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_outs_valid", outs_valid, 0);
    checkOutput("async_rst_index", index, 0);
    m_ptr   = 0;
    m_valid = 1'b0;
    exp_q.delete();
    ins_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'b1111, 1'b1);
    checkOutput("post_rst_first_grant", index, 0);
    applyStimulus(4'b1111, 1'b1);

    repeat (60) applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    applyStimulus(4'b0000, 1'b1);

    // Non-power-of-2 instance: pointer must wrap at 3.
    @(negedge clk);
    ins_valid3  = 3'b111;
    outs_ready3 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      checkOutput("n3_outs_valid", outs_valid3, 1);
      checkOutput("n3_index", index3, FIXED ? 0 : k % 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
